// File: rtl/mem_wb_arb_pkg.sv
// Shared types, default widths and helpers for the mem_wb round-robin arbiter.
package mem_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int DEF_N_MASTERS = 4;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_TIMEOUT   = 15;
  localparam int CNT_W         = 8;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_wb_arbiter_rr_picker.sv
// Combinational round-robin select: first requester after i_last, wrapping.
module rr_picker
  import mem_wb_arb_pkg::*;
#(
  parameter int N     = DEF_N_MASTERS,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  logic [IDX_W-1:0] w_idx;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_last) + k) % N);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_wb_arbiter.sv
// Round-robin arbiter sharing one mem_wb slave port, with bounded-wait timeout.
module mem_wb_arbiter
  import mem_wb_arb_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int GW       = clog2_min1(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_strb,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ack,
  output logic [GW-1:0]                 grant_id,
  output arb_state_t                    dbg_state
);

  // Handshake: a master raises m_req with stable we/addr/wdata and holds it
  // until its one-cycle m_ack; the slave sees s_strb held with stable fields
  // until it returns a one-cycle s_ack.

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  arb_state_t            r_state, w_state;
  logic [GW-1:0]         r_last, w_last;
  logic [GW-1:0]         r_gid, w_gid;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic                  r_strb, w_strb;
  logic                  r_we, w_we;
  logic [ADDR_W-1:0]     r_addr, w_addr;
  logic [DATA_W-1:0]     r_wdata, w_wdata;
  logic [DATA_W-1:0]     r_rdata, w_rdata;
  logic [N_MASTERS-1:0]  r_ack, w_ack;
  logic [N_MASTERS-1:0]  r_err, w_err;
  logic                  w_pick_valid;
  logic [GW-1:0]         w_pick;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  rr_picker #(.N(N_MASTERS), .IDX_W(GW)) u_picker (
    .i_req   (m_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_index (w_pick)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_last  <= GW'(N_MASTERS - 1);
      r_gid   <= '0;
      r_cnt   <= '0;
      r_strb  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_gid   <= w_gid;
      r_cnt   <= w_cnt;
      r_strb  <= w_strb;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_ack   <= w_ack;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_gid   = r_gid;
    w_cnt   = r_cnt;
    w_strb  = r_strb;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rdata = r_rdata;
    w_ack   = '0;
    w_err   = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_strb  = 1'b1;
          w_we    = m_we[w_pick];
          w_addr  = m_addr[w_pick*ADDR_W +: ADDR_W];
          w_wdata = m_wdata[w_pick*DATA_W +: DATA_W];
          w_gid   = w_pick;
          w_last  = w_pick;
          w_cnt   = '0;
          w_state = BUSY;
        end
      end
      BUSY: begin
        // s_ack is checked first so it beats a timeout landing on the same cycle.
        if (s_ack) begin
          if (!r_we) w_rdata = s_rdata;
          w_ack[r_gid] = 1'b1;
          w_strb       = 1'b0;
          w_state      = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_ack[r_gid] = 1'b1;
          w_err[r_gid] = 1'b1;
          w_strb       = 1'b0;
          w_state      = DONE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_cnt   = '0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign m_ack     = r_ack;
  assign m_err     = r_err;
  assign m_rdata   = r_rdata;
  assign s_strb    = r_strb;
  assign s_we      = r_we;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign grant_id  = r_gid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Directed + randomized bench for mem_wb_arbiter against a transaction-level model.
module tb_mem_wb_arbiter;
  import mem_wb_arb_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int T     = 15;
  localparam int GW    = 2;
  localparam int NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      m_req, m_we, m_ack, m_err;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [DW-1:0]     m_rdata;
  logic              s_strb, s_we, s_ack;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [GW-1:0]     grant_id;
  arb_state_t        dbg_state;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_wb_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_strb(s_strb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // slave: acks once the strobe has been seen high for slave_lat cycles
  logic [DW-1:0] slave_mem [256];
  int slave_lat = 1;
  int strb_cnt = 0;

  initial begin
    s_ack = 1'b0;
    s_rdata = '0;
    for (int a = 0; a < 256; a++) slave_mem[a] = 8'h11;
    forever begin
      @(posedge clk); #1;
      if (s_strb && strb_cnt == slave_lat) begin
        s_ack = 1'b1;
        if (s_we) begin
          slave_mem[s_addr] = s_wdata;
          s_rdata = DW'($urandom);
        end else begin
          s_rdata = slave_mem[s_addr];
        end
      end else begin
        s_ack = 1'b0;
        s_rdata = DW'($urandom);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    strb_cnt = s_strb ? strb_cnt + 1 : 0;
  end

  // reference model state
  int             last_g = N - 1;
  logic [GW-1:0]  exp_gid = '0;
  logic [DW-1:0]  exp_rdata = '0;
  logic [DW-1:0]  exp_mem [256];
  logic           rq_we [N];
  logic [AW-1:0]  rq_addr [N];
  logic [DW-1:0]  rq_wdata [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      rq_we[i]    = 1'($urandom_range(0, 1));
      rq_addr[i]  = AW'($urandom_range(0, 15));
      rq_wdata[i] = DW'($urandom);
    end
  endtask

  // Driver + scoreboard for one burst of simultaneous requests.
  task automatic run_round(input logic [N-1:0] mask, input int lat, input logic early_drop);
    int order[$];
    int g[$];
    int ack_at[$];
    int cur, idx, d, k_end, w, cur_j;
    logic found, is_err;
    logic [N-1:0] pend, exp_ack, exp_err;
    logic exp_strb;

    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        m_we[i] = rq_we[i];
        m_addr[i*AW +: AW] = rq_addr[i];
        m_wdata[i*DW +: DW] = rq_wdata[i];
      end
    end
    slave_lat = lat;
    m_req = mask;

    is_err = (lat > T);
    d = is_err ? T : lat;
    cur = last_g;
    pend = mask;
    while (pend != '0) begin
      found = 1'b0;
      idx = 0;
      for (int s = 1; s <= N; s++) begin
        if (!found && pend[GW'((cur + s) % N)]) begin
          idx = (cur + s) % N;
          found = 1'b1;
        end
      end
      order.push_back(idx);
      pend[GW'(idx)] = 1'b0;
      cur = idx;
    end
    for (int j = 0; j < order.size(); j++) begin
      g.push_back(1 + j * (d + 3));
      ack_at.push_back(1 + j * (d + 3) + d + 1);
    end
    k_end = ack_at[ack_at.size() - 1] + 2;

    for (int k = 1; k <= k_end; k++) begin
      @(posedge clk); @(negedge clk);
      exp_strb = 1'b0;
      exp_ack = '0;
      exp_err = '0;
      cur_j = -1;
      for (int j = 0; j < order.size(); j++) begin
        if (k >= g[j]) exp_gid = GW'(order[j]);
        if (k >= g[j] && k <= g[j] + d) begin
          exp_strb = 1'b1;
          cur_j = j;
        end
        if (k == ack_at[j]) begin
          w = order[j];
          exp_ack[GW'(w)] = 1'b1;
          exp_err[GW'(w)] = is_err;
          if (!is_err) begin
            if (rq_we[w]) exp_mem[rq_addr[w]] = rq_wdata[w];
            else exp_rdata = exp_mem[rq_addr[w]];
          end
        end
      end
      check($sformatf("s_strb k=%0d", k), 32'(s_strb), 32'(exp_strb));
      check($sformatf("m_ack k=%0d", k), 32'(m_ack), 32'(exp_ack));
      check($sformatf("m_err k=%0d", k), 32'(m_err), 32'(exp_err));
      check($sformatf("grant_id k=%0d", k), 32'(grant_id), 32'(exp_gid));
      check($sformatf("m_rdata k=%0d", k), 32'(m_rdata), 32'(exp_rdata));
      if (cur_j >= 0) begin
        w = order[cur_j];
        check($sformatf("s_we k=%0d", k), 32'(s_we), 32'(rq_we[w]));
        check($sformatf("s_addr k=%0d", k), 32'(s_addr), 32'(rq_addr[w]));
        check($sformatf("s_wdata k=%0d", k), 32'(s_wdata), 32'(rq_wdata[w]));
      end
      for (int j = 0; j < order.size(); j++) begin
        if (k == ack_at[j] || (early_drop && k == g[j])) m_req[GW'(order[j])] = 1'b0;
      end
    end
    last_g = order[order.size() - 1];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " s_strb"}, 32'(s_strb), 32'd0);
    check({tag, " s_we"}, 32'(s_we), 32'd0);
    check({tag, " s_addr"}, 32'(s_addr), 32'd0);
    check({tag, " s_wdata"}, 32'(s_wdata), 32'd0);
    check({tag, " m_ack"}, 32'(m_ack), 32'd0);
    check({tag, " m_err"}, 32'(m_err), 32'd0);
    check({tag, " m_rdata"}, 32'(m_rdata), 32'd0);
    check({tag, " grant_id"}, 32'(grant_id), 32'd0);
    check({tag, " state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    int lat;
    logic [N-1:0] mask;
    m_req = '0;
    m_we = '0;
    m_addr = '0;
    m_wdata = '0;
    for (int a = 0; a < 256; a++) exp_mem[a] = 8'h11;

    // power-on reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // contention: all four hold until acked, expect 0,1,2,3
    randomize_reqs();
    run_round(4'b1111, 1, 1'b0);

    // wrap: last grant was 3, masters 3 and 0 -> 0 then 3
    randomize_reqs();
    run_round(4'b1001, 1, 1'b0);

    // single write then read-back on master 1
    rq_we[1] = 1'b1; rq_addr[1] = 8'h3C; rq_wdata[1] = 8'hA5;
    run_round(4'b0010, 1, 1'b0);
    rq_we[1] = 1'b0; rq_addr[1] = 8'h3C; rq_wdata[1] = DW'($urandom);
    run_round(4'b0010, 1, 1'b0);

    // read of an unwritten address
    rq_we[2] = 1'b0; rq_addr[2] = 8'hC3; rq_wdata[2] = '0;
    run_round(4'b0100, 1, 1'b0);

    // timeout on master 2, then others still served
    randomize_reqs();
    run_round(4'b0100, NEVER, 1'b0);
    randomize_reqs();
    run_round(4'b1011, 2, 1'b0);

    // s_ack on the exact timeout cycle wins; one cycle later is an error
    randomize_reqs();
    run_round(4'b0001, T, 1'b0);
    randomize_reqs();
    run_round(4'b0010, T + 1, 1'b0);

    // requester drops m_req while busy: transaction still completes
    randomize_reqs();
    run_round(4'b1000, 3, 1'b1);

    // asynchronous reset in the middle of a busy transaction
    randomize_reqs();
    m_we[1] = rq_we[1];
    m_addr[1*AW +: AW] = rq_addr[1];
    m_wdata[1*DW +: DW] = rq_wdata[1];
    slave_lat = 5;
    m_req = 4'b0010;
    @(posedge clk); @(negedge clk);
    check("pre-reset s_strb", 32'(s_strb), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    m_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset m_ack", 32'(m_ack), 32'd0);
    last_g = N - 1;
    exp_gid = '0;
    exp_rdata = '0;
    randomize_reqs();
    run_round(4'b0101, 1, 1'b0);

    // randomized bursts
    for (int r = 0; r < 10; r++) begin
      randomize_reqs();
      mask = N'($urandom_range(1, (1 << N) - 1));
      lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 4));
      run_round(mask, lat, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_arbiter.md
Name: mem_wb_arbiter

Overview:
- Round-robin arbiter that shares one mem_wb slave port (strb/we/addr/wdata in, rdata/ack out) between N_MASTERS requesters.
- Sits between the requesters and mem_wb.
- Registers the winning request onto the slave bus, holds it stable until the slave acks, then returns a registered ack/rdata to the winner.
- A bounded-wait timeout returns an error response if the slave never acks.

Parameters:
- N_MASTERS, 4, number of requesters (2..8)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TIMEOUT, 15, max cycles in BUSY without s_ack before error (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  N_MASTERS  per-master request; held high until that master's m_ack
- m_we  in  N_MASTERS  per-master write enable (1=write, 0=read)
- m_addr  in  N_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  packed write data
- m_ack  out  N_MASTERS  one-hot, one-cycle completion pulse
- m_err  out  N_MASTERS  one-cycle timeout pulse, coincident with m_ack
- m_rdata  out  DATA_W  shared read data; valid while the winner's m_ack=1 for reads
- s_strb  out  1  slave strobe
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data, valid while s_ack=1
- s_ack  in  1  slave acknowledge
- grant_id  out  clog2(N_MASTERS)  index of current/last winner

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE.
  - s_strb, s_we, m_ack, m_err = 0; s_addr, s_wdata, m_rdata = 0.
  - last_grant=N_MASTERS-1, so master 0 has top priority first; grant_id=0; timeout counter=0.
- FSM IDLE → BUSY → DONE → IDLE:
  - IDLE:
    - If any m_req, pick the first requester searching from (last_grant+1) mod N_MASTERS upward with wrap.
    - Register s_strb=1 and that master's we/addr/wdata; set grant_id and last_grant; go to BUSY. Otherwise stay.
  - BUSY:
    - Slave outputs held stable; counter increments each cycle.
    - On s_ack=1: capture s_rdata into m_rdata, set m_ack[grant]=1, s_strb=0, go to DONE.
    - On counter reaching TIMEOUT with s_ack=0: m_ack[grant]=1, m_err[grant]=1, s_strb=0, go to DONE.
    - If s_ack and timeout occur in the same cycle, s_ack wins (no error).
  - DONE:
    - m_ack/m_err high this cycle only; counter cleared.
    - Requests are not sampled, so the winner can drop m_req; next cycle IDLE.
- Latency:
  - With the slave in check_mode, m_req at cycle 0 gives s_strb at 1, s_ack at 2, m_ack at 3.
  - Minimum spacing between grants is 4 cycles. This spacing also guarantees mem_wb passes through idle and sees s_strb=0 before the next strobe.
- s_strb is never high in DONE or IDLE, so no back-to-back double issue to the slave.
- A requester dropping m_req while in BUSY does not abort; the transaction completes and its ack is still pulsed.
- m_req changes on non-granted masters during BUSY are ignored until the next IDLE.
- s_ack seen in IDLE or DONE is ignored.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,3,0,…
- m_rdata holds its last value between reads. After a write it is unchanged.
- Reset mid-transaction: all outputs return to reset values immediately. The pending transaction is dropped without an ack.

Decomposition:
- Package mem_wb_arb_pkg: state enum (IDLE, BUSY, DONE), default widths, and function clog2_min1.
- Sub-module rr_picker (combinational round-robin priority select):
  - Inputs: req vector and last_grant.
  - Outputs: valid and index.
  - Instantiated once.

Test Plan:
- Single write: master 1 write addr 0x3C data 0xA5 → s_strb high with addr 0x3C/wdata 0xA5 until s_ack; m_ack[1] pulses once 3 cycles after m_req.
- Then master 1 reads 0x3C → m_rdata=0xA5 with m_ack[1]. A read of an unwritten address → 0x11.
- Contention: all 4 masters request at once, each holding until ack → grant order 0,1,2,3; no master granted twice before all served; s_strb low ≥2 cycles between transactions.
- Timeout: s_ack tied 0, master 2 requests → m_ack[2]=m_err[2]=1 exactly TIMEOUT+1 cycles after grant; s_strb drops; other masters still served afterwards.
- Reset mid-BUSY: assert rst_n=0 asynchronously between edges → s_strb, m_ack go 0 without waiting for clk; after release, master 0 wins first.
- Wrap/edge: last_grant=3, only masters 3 and 0 requesting → 0 granted next, then 3; simultaneous s_ack on the TIMEOUT cycle → m_err stays 0.
